// File: rtl/kfmmc_pkg.sv
// Shared types and helpers for the MMC command/data line engines.
package kfmmc_pkg;

    typedef enum logic [1:0] {
        PHY_IDLE       = 2'd0,
        PHY_WAIT_START = 2'd1,
        PHY_SHIFT      = 2'd2
    } phy_state_t;

    // x^7 + x^3 + 1 with the x^7 term implicit
    localparam logic [6:0] CRC7_POLY = 7'h09;

    // Advance a CRC7 by one serial bit, MSB-first
    function automatic logic [6:0] crc7_update(input logic [6:0] crc, input logic din);
        logic fb;
        fb = crc[6] ^ din;
        return {crc[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'h00);
    endfunction

endpackage

// File: rtl/kfmmc_clock_divider.sv
// MMC clock generator: idles high, toggles every divide+1 system clocks while
// enabled and flags the edge it is about to make so the bit engine can act on
// the same system clock edge.
module kfmmc_clock_divider
    import kfmmc_pkg::*;
#(
    parameter int DIV_WIDTH = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 enable_i,
    input  logic [DIV_WIDTH-1:0] divide_i,
    output logic                 mmc_clk_o,
    output logic                 rise_o,
    output logic                 fall_o
);

    logic [DIV_WIDTH-1:0] cnt_q;
    logic                 clk_q;
    logic                 tc;

    assign tc        = enable_i && (cnt_q == '0);
    assign rise_o    = tc && !clk_q;
    assign fall_o    = tc && clk_q;
    assign mmc_clk_o = clk_q;

    // Down-counter reloads on terminal count; parked high and reloaded while disabled
    always_ff @(negedge clock or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
            clk_q <= 1'b1;
        end else if (!enable_i) begin
            cnt_q <= divide_i;
            clk_q <= 1'b1;
        end else if (tc) begin
            cnt_q <= divide_i;
            clk_q <= ~clk_q;
        end else begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

endmodule

// File: rtl/kfmmc_command_line_phy.sv
// MMC CMD line bit engine: moves one byte per request, MSB-first, with CRC7.
//
//   state          | meaning
//   PHY_IDLE       | waiting for start_communication
//   PHY_WAIT_START | receive: MMC clock running, waiting for CMD to go low
//   PHY_SHIFT      | moving bits; ends on the 8th rising MMC clock edge
module kfmmc_command_line_phy
    import kfmmc_pkg::*;
#(
    parameter int DIV_WIDTH = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [DIV_WIDTH-1:0] mmc_clock_divide,
    input  logic                 start_communication,
    input  logic                 command_io,
    input  logic                 check_command_start_bit,
    input  logic                 clear_command_crc,
    input  logic                 clear_command_interrupt,
    input  logic                 mask_command_interrupt,
    input  logic                 set_send_command,
    input  logic [7:0]           send_command,
    output logic [7:0]           received_response,
    output logic [6:0]           send_command_crc,
    output logic [6:0]           received_response_crc,
    output logic                 mmc_is_in_connecting,
    output logic                 sent_command_interrupt,
    output logic                 received_response_interrupt,
    output logic                 mmc_clk,
    output logic                 mmc_cmd_out,
    output logic                 mmc_cmd_oe,
    input  logic                 mmc_cmd_in
);

    phy_state_t state_q;
    logic       busy_q;
    logic       io_q;
    logic [3:0] bit_cnt_q;
    logic [7:0] tx_sh_q;
    logic [7:0] rx_sh_q;
    logic [7:0] resp_q;
    logic [6:0] tx_crc_q;
    logic [6:0] rx_crc_q;
    logic       tx_flag_q;
    logic       rx_flag_q;
    logic       cmd_out_q;
    logic       cmd_oe_q;

    logic       mclk_rise;
    logic       mclk_fall;
    logic [6:0] tx_crc_d;
    logic [6:0] rx_crc_d;
    logic [7:0] rx_sh_d;

    kfmmc_clock_divider #(.DIV_WIDTH(DIV_WIDTH)) u_div (
        .clock     (clock),
        .reset     (reset),
        .enable_i  (busy_q),
        .divide_i  (mmc_clock_divide),
        .mmc_clk_o (mmc_clk),
        .rise_o    (mclk_rise),
        .fall_o    (mclk_fall)
    );

    assign tx_crc_d = crc7_update(tx_crc_q, tx_sh_q[7]);
    assign rx_crc_d = crc7_update(rx_crc_q, mmc_cmd_in);
    assign rx_sh_d  = {rx_sh_q[6:0], mmc_cmd_in};

    // Transfer FSM with registered CMD drive, shifters, CRCs and sticky flags
    always_ff @(negedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= PHY_IDLE;
            busy_q    <= 1'b0;
            io_q      <= 1'b0;
            bit_cnt_q <= 4'd0;
            tx_sh_q   <= 8'h00;
            rx_sh_q   <= 8'h00;
            resp_q    <= 8'hFF;
            tx_crc_q  <= 7'h00;
            rx_crc_q  <= 7'h00;
            tx_flag_q <= 1'b0;
            rx_flag_q <= 1'b0;
            cmd_out_q <= 1'b1;
            cmd_oe_q  <= 1'b0;
        end else begin
            // Clear first so a completion later in this block takes priority
            if (clear_command_interrupt) begin
                tx_flag_q <= 1'b0;
                rx_flag_q <= 1'b0;
            end
            case (state_q)
                PHY_IDLE: begin
                    if (start_communication) begin
                        busy_q    <= 1'b1;
                        io_q      <= command_io;
                        bit_cnt_q <= 4'd8;
                        if (set_send_command) tx_sh_q <= send_command;
                        if (clear_command_crc) begin
                            tx_crc_q <= 7'h00;
                            rx_crc_q <= 7'h00;
                        end
                        if (command_io) begin
                            cmd_out_q <= 1'b1;
                            cmd_oe_q  <= 1'b0;
                        end
                        state_q <= (command_io && check_command_start_bit) ? PHY_WAIT_START
                                                                           : PHY_SHIFT;
                    end
                end
                PHY_WAIT_START: begin
                    // The start bit itself is the first of the eight bits
                    if (mclk_rise && !mmc_cmd_in) begin
                        rx_sh_q   <= rx_sh_d;
                        rx_crc_q  <= rx_crc_d;
                        bit_cnt_q <= 4'd7;
                        state_q   <= PHY_SHIFT;
                    end
                end
                PHY_SHIFT: begin
                    if (mclk_fall && !io_q) begin
                        cmd_out_q <= tx_sh_q[7];
                        cmd_oe_q  <= 1'b1;
                    end
                    if (mclk_rise) begin
                        bit_cnt_q <= bit_cnt_q - 4'd1;
                        if (io_q) begin
                            rx_sh_q  <= rx_sh_d;
                            rx_crc_q <= rx_crc_d;
                        end else begin
                            tx_crc_q <= tx_crc_d;
                            tx_sh_q  <= {tx_sh_q[6:0], 1'b1};
                        end
                        if (bit_cnt_q == 4'd1) begin
                            busy_q  <= 1'b0;
                            state_q <= PHY_IDLE;
                            if (io_q) begin
                                resp_q    <= rx_sh_d;
                                rx_flag_q <= 1'b1;
                            end else begin
                                tx_flag_q <= 1'b1;
                            end
                        end
                    end
                end
                default: state_q <= PHY_IDLE;
            endcase
        end
    end

    assign received_response           = resp_q;
    assign send_command_crc            = tx_crc_q;
    assign received_response_crc       = rx_crc_q;
    assign mmc_is_in_connecting        = busy_q;
    assign sent_command_interrupt      = tx_flag_q & ~mask_command_interrupt;
    assign received_response_interrupt = rx_flag_q & ~mask_command_interrupt;
    assign mmc_cmd_out                 = cmd_out_q;
    assign mmc_cmd_oe                  = cmd_oe_q;

endmodule

// File: tb/tb_kfmmc_command_line_phy.sv
// Directed bench for the MMC CMD line phy with a transaction-level model.
module tb_kfmmc_command_line_phy;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] div = 8'd0;
    logic       start = 1'b0, cmd_io = 1'b0, chk_start = 1'b0, clr_crc = 1'b0;
    logic       clr_irq = 1'b0, mask = 1'b0, set_send = 1'b0;
    logic [7:0] send = 8'h00;
    logic       cin = 1'b1;
    logic [7:0] resp;
    logic [6:0] tcrc, rcrc;
    logic       busy, sirq, rirq, mclk, cout, coe;

    kfmmc_command_line_phy #(.DIV_WIDTH(8)) dut (
        .clock                       (clock),
        .reset                       (reset),
        .mmc_clock_divide            (div),
        .start_communication         (start),
        .command_io                  (cmd_io),
        .check_command_start_bit     (chk_start),
        .clear_command_crc           (clr_crc),
        .clear_command_interrupt     (clr_irq),
        .mask_command_interrupt      (mask),
        .set_send_command            (set_send),
        .send_command                (send),
        .received_response           (resp),
        .send_command_crc            (tcrc),
        .received_response_crc       (rcrc),
        .mmc_is_in_connecting        (busy),
        .sent_command_interrupt      (sirq),
        .received_response_interrupt (rirq),
        .mmc_clk                     (mclk),
        .mmc_cmd_out                 (cout),
        .mmc_cmd_oe                  (coe),
        .mmc_cmd_in                  (cin)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        total++;
        bad++;
        $display("FAIL %s: event did not occur (t=%0t)", name, $time);
    endtask

    // ---------------- model ----------------
    int         exp_bits[$];
    logic [7:0] exp_tx[$];
    logic [7:0] exp_rx[$];
    int         rx_drive[$];
    bit         tx_hist[$];
    bit         rx_hist[$];
    bit         m_txf, m_rxf, cur_rx, prev_busy, prev_clk, seen_first;
    logic [7:0] m_resp = 8'hFF;
    logic [7:0] obs = 8'h00;
    int         cyc, nbits;

    // CRC7 as the remainder of message*x^7 divided by x^7+x^3+1 (long division)
    function automatic logic [6:0] crc_div(input bit h[$]);
        bit         m[$];
        int         n;
        logic [6:0] r;
        m = h;
        n = h.size();
        for (int k = 0; k < 7; k++) m.push_back(1'b0);
        for (int i = 0; i < n; i++) begin
            if (m[i]) begin
                m[i]     = ~m[i];
                m[i + 4] = ~m[i + 4];
                m[i + 7] = ~m[i + 7];
            end
        end
        for (int j = 0; j < 7; j++) r[6 - j] = m[n + j];
        return r;
    endfunction

    // Receive-side line driver: next bit appears just after each MMC clock fall
    always @(negedge mclk) begin
        #1;
        if (rx_drive.size() > 0) cin = (rx_drive.pop_front() != 0);
        else cin = 1'b1;
    end

    // Compare process: sampled on the rising system clock, away from the active edge
    always @(posedge clock) begin
        logic [7:0] b;
        int         e;
        if (reset) begin
            exp_bits.delete(); exp_tx.delete(); exp_rx.delete(); rx_drive.delete();
            tx_hist.delete(); rx_hist.delete();
            m_txf = 0; m_rxf = 0; m_resp = 8'hFF; cur_rx = 0;
            prev_busy = 0; prev_clk = 1; seen_first = 0; cyc = 0; nbits = 0;
        end else begin
            if (clr_irq) begin m_txf = 0; m_rxf = 0; end
            if (busy && !prev_busy) begin
                cur_rx = cmd_io; nbits = 0; seen_first = 0; cyc = 0;
                if (clr_crc) begin tx_hist.delete(); rx_hist.delete(); end
            end
            if (busy) begin
                cyc++;
                if (mclk !== prev_clk) begin
                    if (seen_first) chk("half_period", cyc, div + 1);
                    seen_first = 1; cyc = 0;
                end
                if (cur_rx) chk("rx_oe", coe, 0);
                else if (prev_clk && !mclk) begin
                    if (exp_bits.size() == 0) fail_now("tx_bit_avail");
                    else begin
                        e = exp_bits.pop_front();
                        chk("tx_bit", cout, e);
                        chk("tx_oe", coe, 1);
                        obs = {obs[6:0], cout};
                        nbits++;
                    end
                end
            end
            if (!busy && prev_busy) begin
                if (cur_rx) begin
                    if (exp_rx.size() == 0) fail_now("rx_expect_avail");
                    else begin
                        b = exp_rx.pop_front();
                        m_resp = b; m_rxf = 1;
                        for (int i = 7; i >= 0; i--) rx_hist.push_back(b[i]);
                    end
                end else begin
                    chk("tx_bits_per_xfer", nbits, 8);
                    if (exp_tx.size() == 0) fail_now("tx_expect_avail");
                    else begin
                        b = exp_tx.pop_front();
                        m_txf = 1;
                        for (int i = 7; i >= 0; i--) tx_hist.push_back(b[i]);
                    end
                end
            end
            chk("tx_irq", sirq, m_txf && !mask);
            chk("rx_irq", rirq, m_rxf && !mask);
            chk("resp", resp, m_resp);
            if (!busy) begin
                chk("idle_clk", mclk, 1);
                chk("tx_crc", tcrc, crc_div(tx_hist));
                chk("rx_crc", rcrc, crc_div(rx_hist));
                if (cur_rx) begin
                    chk("idle_oe", coe, 0);
                    chk("idle_out", cout, 1);
                end
            end
            prev_busy = busy;
            prev_clk  = mclk;
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_busy(input logic v, input int limit, input string name, output int n);
        n = 0;
        while (busy !== v && n < limit) begin
            tick();
            n++;
        end
        if (busy !== v) fail_now(name);
    endtask

    task automatic push_tx(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) exp_bits.push_back(b[i]);
        exp_tx.push_back(b);
    endtask

    task automatic push_rx(input logic [7:0] b, input int idle_ones);
        for (int i = 0; i < idle_ones; i++) rx_drive.push_back(1);
        for (int i = 7; i >= 0; i--) rx_drive.push_back(b[i]);
        exp_rx.push_back(b);
    endtask

    task automatic launch(input logic io, input logic [7:0] b, input logic clr,
                          input logic cs, input logic [7:0] d);
        div = d; cmd_io = io; send = b; set_send = !io; clr_crc = clr; chk_start = cs;
        if (!io) push_tx(b);
        start = 1'b1;
    endtask

    task automatic xfer(input logic io, input logic [7:0] b, input logic clr,
                        input logic cs, input logic [7:0] d);
        int n;
        launch(io, b, clr, cs, d);
        wait_busy(1'b1, 20, "accept_timeout", n);
        start = 1'b0; set_send = 1'b0; clr_crc = 1'b0;
        wait_busy(1'b0, 3000, "done_timeout", n);
        tick();
    endtask

    task automatic pulse_clear();
        clr_irq = 1'b1;
        tick();
        clr_irq = 1'b0;
        tick();
    endtask

    initial begin
        int n;
        repeat (3) tick();
        reset = 1'b0;
        tick();
        chk("rst_resp", resp, 8'hFF);
        chk("rst_clk", mclk, 1);
        chk("rst_out", cout, 1);
        chk("rst_oe", coe, 0);
        chk("rst_busy", busy, 0);

        // single byte 0x40 at full speed
        xfer(1'b0, 8'h40, 1'b1, 1'b0, 8'd0);
        chk("t1_bits", obs, 8'h40);
        chk("t1_irq", sirq, 1);
        chk("t1_busy", busy, 0);

        // CMD0 frame with a slower MMC clock, then its CRC byte
        xfer(1'b0, 8'h40, 1'b1, 1'b0, 8'd2);
        for (int i = 0; i < 4; i++) xfer(1'b0, 8'h00, 1'b0, 1'b0, 8'd2);
        chk("cmd0_crc", tcrc, 7'h4A);
        xfer(1'b0, 8'h95, 1'b0, 1'b0, 8'd1);
        chk("crc_byte_bits", obs, 8'h95);

        // receive with start-bit hunt, then masking
        pulse_clear();
        push_rx(8'h3F, 20);
        xfer(1'b1, 8'h3F, 1'b1, 1'b1, 8'd3);
        chk("rx_resp", resp, 8'h3F);
        chk("rx_irq_set", rirq, 1);
        mask = 1'b1;
        tick();
        chk("rx_irq_masked", rirq, 0);
        mask = 1'b0;
        tick();
        chk("rx_irq_retained", rirq, 1);

        // receive without start-bit hunt
        push_rx(8'hA6, 0);
        xfer(1'b1, 8'hA6, 1'b0, 1'b0, 8'd1);
        chk("rx2_resp", resp, 8'hA6);

        // clear landing on the completion edge
        pulse_clear();
        launch(1'b0, 8'hC3, 1'b0, 1'b0, 8'd0);
        wait_busy(1'b1, 20, "c_accept_timeout", n);
        start = 1'b0; set_send = 1'b0;
        repeat (15) tick();
        clr_irq = 1'b1;
        tick();
        chk("clr_vs_done_busy", busy, 0);
        chk("clr_vs_done_irq", sirq, 1);
        tick();
        chk("clr_after_irq", sirq, 0);
        clr_irq = 1'b0;
        tick();

        // start held across completion: back-to-back transfer
        launch(1'b0, 8'h5A, 1'b0, 1'b0, 8'd1);
        push_tx(8'h5A);
        wait_busy(1'b1, 20, "b2b_accept_timeout", n);
        wait_busy(1'b0, 3000, "b2b_first_done_timeout", n);
        wait_busy(1'b1, 10, "b2b_restart_timeout", n);
        chk("b2b_gap", n, 1);
        start = 1'b0; set_send = 1'b0;
        wait_busy(1'b0, 3000, "b2b_second_done_timeout", n);
        tick();
        chk("b2b_bits", obs, 8'h5A);

        // reset in the middle of a transmit byte
        launch(1'b0, 8'hA5, 1'b0, 1'b0, 8'd1);
        wait_busy(1'b1, 20, "r_accept_timeout", n);
        start = 1'b0; set_send = 1'b0;
        n = 0;
        while (exp_bits.size() > 4 && n < 200) begin
            tick();
            n++;
        end
        if (exp_bits.size() > 4) fail_now("reach_bit4");
        reset = 1'b1;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_clk", mclk, 1);
        chk("mid_rst_out", cout, 1);
        chk("mid_rst_oe", coe, 0);
        chk("mid_rst_sirq", sirq, 0);
        chk("mid_rst_rirq", rirq, 0);
        chk("mid_rst_resp", resp, 8'hFF);
        chk("mid_rst_tcrc", tcrc, 7'h00);
        chk("mid_rst_rcrc", rcrc, 7'h00);
        repeat (3) tick();
        reset = 1'b0;
        repeat (40) tick();
        chk("post_rst_irq", sirq, 0);

        // recovery after reset
        xfer(1'b0, 8'h3C, 1'b1, 1'b0, 8'd0);
        chk("recover_bits", obs, 8'h3C);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish (total=%0d bad=%0d)", total, bad);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/kfmmc_command_line_phy.md
Name: kfmmc_command_line_phy

Overview:
- Bit-level engine for the MMC CMD line; sits directly downstream of the command byte sequencer and consumes its byte-level control strobes.
- Serialises one command byte MSB-first onto CMD, or deserialises one response byte from CMD.
- Generates the MMC clock, accumulates CRC7 over transferred bits and raises per-byte completion interrupts back to the sequencer.
- All registers update on the falling edge of `clock`.

Parameters:
DIV_WIDTH, 8, width of the MMC clock divider input.

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-high reset
mmc_clock_divide  in  DIV_WIDTH  MMC clock half-period = value+1 system clocks
start_communication  in  1  level request to transfer one byte
command_io  in  1  1 = receive (CMD tri-stated), 0 = transmit
check_command_start_bit  in  1  receive: hold off counting until CMD=0
clear_command_crc  in  1  zero both CRC7 accumulators when the request is accepted
clear_command_interrupt  in  1  clear both interrupt flags
mask_command_interrupt  in  1  force interrupt outputs low (flags retained)
set_send_command  in  1  load send_command into the TX shifter on acceptance
send_command  in  8  byte to transmit
received_response  out  8  last received byte
send_command_crc  out  7  CRC7 of bits transmitted since last clear
received_response_crc  out  7  CRC7 of bits received since last clear
mmc_is_in_connecting  out  1  transfer in progress
sent_command_interrupt  out  1  TX byte complete (sticky)
received_response_interrupt  out  1  RX byte complete (sticky)
mmc_clk  out  1  MMC clock, idles high
mmc_cmd_out  out  1  CMD drive value
mmc_cmd_oe  out  1  CMD output enable
mmc_cmd_in  in  1  CMD line sample

Behaviour:
- Reset values:
  - received_response = 8'hFF; both CRCs = 0.
  - in_connecting = 0; both interrupt flags = 0.
  - mmc_clk = 1; cmd_out = 1; cmd_oe = 0.
- States: IDLE, WAIT_START, SHIFT.
- IDLE:
  - start_communication=1 is accepted at that edge. Latch command_io and check_command_start_bit.
  - If set_send_command=1, load the shifter. If clear_command_crc=1, zero both CRCs.
  - bit_count=8. in_connecting=1 from the next cycle.
  - Next state is WAIT_START if receive with check enabled, otherwise SHIFT.
- The requester holds start until it sees in_connecting=1. Start still high when a transfer ends starts a new transfer.
- Divider: counter reloads mmc_clock_divide; mmc_clk toggles at each terminal count.
  - Falling mmc_clk edge: TX drives shifter[7] on cmd_out with cmd_oe=1.
  - Rising mmc_clk edge: samples cmd_in into RX.
- WAIT_START: each rising edge, if cmd_in=0, count that bit as bit 7 (shift it in, update RX CRC), then go to SHIFT with 7 bits remaining. No timeout; sequencer reset is the recovery path.
- SHIFT: per bit, update the relevant CRC7 (x^7+x^3+1, feedback = crc[6]^bit) and decrement bit_count.
- After the 8th bit's rising sample:
  - Transfer register → received_response (RX only); set the TX or RX interrupt flag.
  - in_connecting=0; return to IDLE. mmc_clk is left high.
- TX: cmd_oe stays 1 until transfer end; between transfers cmd_out=1 and cmd_oe=0 if the latched command_io=1.
- Interrupts: outputs = flag & ~mask_command_interrupt.
  - clear_command_interrupt clears both flags.
  - Completion-set wins over a clear on the same edge.
  - Clear together with an accepted start is legal and applies.
- Changes to command_io / set_send_command while busy are ignored.
- received_response holds until the next RX completion.
- Divider value 0: half-period of 1 clock (mmc_clk = clock/2).
- Async reset mid-transfer: immediately returns all state to reset values; no completion interrupt.

Decomposition:
- Package kfmmc_pkg: phy state enum, CRC7 polynomial constant 7'h09, a CRC7 single-bit update function (shared with the data-line phy).
- One sub-module, kfmmc_clock_divider: produces mmc_clk plus rise/fall strobes, enabled only while busy.

Test Plan:
- TX 8'h40, divide=0, set_send, clear_crc → cmd_out bits 0,1,0,0,0,0,0,0 on successive falling edges; sent_command_interrupt after 8 bits; in_connecting low.
- TX bytes 40 00 00 00 00 (CMD0), clear_crc only on the first → send_command_crc=7'h4A; TX {7'h4A,1}=8'h95 next.
- RX with check_start_bit: cmd_in high 20 bits, then 8'h3F pattern → waits, received_response=8'h3F, received_response_interrupt=1, flag retained with mask=1 but output 0.
- Clear and completion on the same edge → flag remains 1; clear next cycle → 0.
- Start held high across completion → second transfer begins, in_connecting returns high one cycle after dropping.
- Reset asserted at bit 4 of TX → all outputs at reset values within the same cycle; no interrupt.
